traffic_phase_sequencer: RTL and testbench
==========================================

Name: traffic_phase_sequencer

Overview:
- Downstream of the mode controller: consumes its 6-bit one-hot `enb` command and runs the selected light phase with cycle-accurate step timers.
- Drives the main-road and country-road lamps and a countdown display.
- Returns a one-cycle feedback pulse per mode, which re-arms the controller to issue the next command.

Parameters:
- GREEN_T, 8, green step length in cycles (>=1)
- YELLOW_T, 3, yellow step length in cycles (>=1)
- ALLRED_T, 2, all-red step length for the reset mode (>=1)
- BLINK_T, 2, half-period of the online-mode yellow blink in cycles (>=1)
- CNT_W, 8, countdown width; must hold max(T)-1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-low reset
- enb  in  6  one-hot command: [0] online, [1] reset mode, [2] country-only (Cm,Cc=01), [3] main-only (10), [4] no cars (00), [5] both (11)
- main_lt  out  3  main-road lamps {R,Y,G}
- cntry_lt  out  3  country-road lamps {R,Y,G}
- count  out  CNT_W  remaining cycles in current step
- busy  out  1  phase in progress (any state except IDLE)
- err  out  1  one-cycle pulse: multi-hot enb accepted
- feedback1, feedback2, feedback3, feedback4, feedbackRst, feedbackOnline  out  1 each  one-cycle completion pulses for enb[5], [4], [3], [2], [1], [0] respectively

Behaviour:
- Reset (rst=0 at a rising edge), from any state, including mid-phase:
  - state=IDLE, main_lt=100, cntry_lt=100 (all red), count=0, busy=0, err=0, all feedback=0.
  - No feedback is emitted for the aborted phase.
- States: IDLE, MG, MY, CG, CY, ALLRED, BLINK_ON, BLINK_OFF, DONE. All outputs are registered.
- Accept: only in IDLE, and only when enb != 0.
  - Multi-hot enb: the lowest-index set bit wins (online has highest priority) and err pulses in the first step cycle.
  - enb=0 keeps the block in IDLE.
  - enb is ignored in every other state.
- Step timing:
  - On entering a step, count loads T-1 and decrements each cycle; the step advances on the edge where count==0.
  - A step of T therefore lasts exactly T cycles.
- Latency: if enb is accepted at edge k, the first step's lamps and busy=1 are visible from cycle k+1.
- Sequences and lamps (main,cntry):
  - enb[5]: MG(001,100) GREEN_T -> MY(010,100) YELLOW_T -> CG(100,001) GREEN_T -> CY(100,010) YELLOW_T -> DONE, pulse feedback1.
  - enb[4]: MG GREEN_T -> DONE, pulse feedback2.
  - enb[3]: MG GREEN_T -> DONE, pulse feedback3.
  - enb[2]: MY YELLOW_T -> CG GREEN_T -> CY YELLOW_T -> DONE, pulse feedback4.
  - enb[1]: ALLRED(100,100) ALLRED_T -> DONE, pulse feedbackRst.
  - enb[0]: BLINK_ON(010,010) -> BLINK_OFF(000,000) -> BLINK_ON -> BLINK_OFF, each BLINK_T cycles -> DONE, pulse feedbackOnline.
- DONE (exactly 1 cycle):
  - Asserts the selected feedback, busy=1, count=0, lamps=(001,100). enb is not sampled.
  - This gives the controller one cycle to update enb.
- IDLE after any completed phase: lamps=(001,100), count=0, busy=0.
- Invariants:
  - At most one feedback is high in any cycle.
  - Each lamp group is one-hot, or 000 only in BLINK_OFF.
  - The main and country roads are never green or yellow simultaneously, except both-yellow in BLINK_ON.

Test Plan:
- rst=0 held 2 cycles, then released with enb=0 -> lamps 100/100, busy=0, count=0 indefinitely; no feedback pulses.
- enb=001000, GREEN_T=8, accepted at edge 0 -> cycles 1–8 main_lt=001 with count 7..0; cycle 9 feedback3=1 (single cycle); cycle 10 IDLE, busy=0.
- enb=100000 held, defaults -> MG 8, MY 3, CG 8, CY 3 cycles with the lamp codes above; feedback1 in cycle 23; enb still 100000 in IDLE re-accepts, and the next MG starts in cycle 25.
- enb=000001, BLINK_T=2 -> lamps 010/010 for 2 cycles, 000/000 for 2, 010/010 for 2, 000/000 for 2; feedbackOnline in cycle 9.
- enb=000011 -> err=1 in cycle 1; online sequence runs; no feedbackRst.
- enb=000100 with rst=0 applied in cycle 5 (during CG) -> next cycle all outputs at reset values; no feedback4 ever; the new command is accepted only after rst=1.

Source files
------------

// File: rtl/traffic_phase_sequencer.sv
// ----------------------------------------------------------------------------
// traffic_phase_sequencer
//
// Runs one light phase per one-hot command from the mode controller. Each
// phase is a fixed sequence of timed steps. Every step lasts exactly its
// configured number of cycles. A single DONE cycle follows the last step and
// pulses the feedback line that belongs to the command, which tells the
// controller to issue its next command.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous, active-low reset
//   enb[5:0]       one-hot command; the lowest set bit wins when several are set
//                  [0] online blink, [1] reset (all red), [2] country only,
//                  [3] main only, [4] no cars, [5] both roads
//   main_lt[2:0]   main-road lamps {R,Y,G}
//   cntry_lt[2:0]  country-road lamps {R,Y,G}
//   count          cycles remaining in the current step (0 in IDLE/DONE)
//   busy           high in every state except IDLE
//   err            one-cycle pulse in the first step after a multi-hot enb
//   feedback1..4, feedbackRst, feedbackOnline
//                  one-cycle completion pulses for enb[5], [4], [3], [2],
//                  [1] and [0] respectively
// All outputs are registered.
// ----------------------------------------------------------------------------
module traffic_phase_sequencer #(
    parameter int unsigned GREEN_T  = 8,
    parameter int unsigned YELLOW_T = 3,
    parameter int unsigned ALLRED_T = 2,
    parameter int unsigned BLINK_T  = 2,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       enb,
    output logic [2:0]       main_lt,
    output logic [2:0]       cntry_lt,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             err,
    output logic             feedback1,
    output logic             feedback2,
    output logic             feedback3,
    output logic             feedback4,
    output logic             feedbackRst,
    output logic             feedbackOnline
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_MG        = 4'd1;
    localparam logic [3:0] S_MY        = 4'd2;
    localparam logic [3:0] S_CG        = 4'd3;
    localparam logic [3:0] S_CY        = 4'd4;
    localparam logic [3:0] S_ALLRED    = 4'd5;
    localparam logic [3:0] S_BLINK_ON  = 4'd6;
    localparam logic [3:0] S_BLINK_OFF = 4'd7;
    localparam logic [3:0] S_DONE      = 4'd8;

    // Command index, equal to the enb bit that started the phase
    localparam logic [2:0] M_ONLINE  = 3'd0;
    localparam logic [2:0] M_RESET   = 3'd1;
    localparam logic [2:0] M_COUNTRY = 3'd2;
    localparam logic [2:0] M_MAIN    = 3'd3;
    localparam logic [2:0] M_NOCARS  = 3'd4;
    localparam logic [2:0] M_BOTH    = 3'd5;

    // Lamp codes {R,Y,G}
    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;
    localparam logic [2:0] L_OFF = 3'b000;

    // Counter load values: a step of T cycles counts T-1 down to 0
    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] BLINK_LD  = CNT_W'(BLINK_T - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [3:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [2:0]       mode_q,   mode_d;
    logic             blink2_q, blink2_d;   // second ON/OFF pair in progress
    logic [2:0]       main_q,   main_d;
    logic [2:0]       cntry_q,  cntry_d;
    logic             busy_q,   busy_d;
    logic             err_q,    err_d;
    logic [5:0]       fb_q,     fb_d;       // bit i answers enb[i]

    logic             accept;
    logic             multi_hot;
    logic [2:0]       sel_mode;

    // ------------------------------------------------------------------
    // Command decode: lowest-index set bit has priority
    // ------------------------------------------------------------------
    always_comb begin
        sel_mode = M_ONLINE;
        if (enb[0]) begin
            sel_mode = M_ONLINE;
        end else if (enb[1]) begin
            sel_mode = M_RESET;
        end else if (enb[2]) begin
            sel_mode = M_COUNTRY;
        end else if (enb[3]) begin
            sel_mode = M_MAIN;
        end else if (enb[4]) begin
            sel_mode = M_NOCARS;
        end else begin
            sel_mode = M_BOTH;
        end
    end

    assign accept    = (state_q == S_IDLE) && (enb != '0);
    assign multi_hot = (enb & (enb - 6'd1)) != '0;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        blink2_d = blink2_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    mode_d   = sel_mode;
                    blink2_d = 1'b0;
                    case (sel_mode)
                        M_ONLINE: begin
                            state_d = S_BLINK_ON;
                            cnt_d   = BLINK_LD;
                        end
                        M_RESET: begin
                            state_d = S_ALLRED;
                            cnt_d   = ALLRED_LD;
                        end
                        M_COUNTRY: begin
                            state_d = S_MY;
                            cnt_d   = YELLOW_LD;
                        end
                        default: begin
                            state_d = S_MG;
                            cnt_d   = GREEN_LD;
                        end
                    endcase
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end

            default: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    case (state_q)
                        S_MG: begin
                            // Only the two-road command continues past main green
                            if (mode_q == M_BOTH) begin
                                state_d = S_MY;
                                cnt_d   = YELLOW_LD;
                            end else begin
                                state_d = S_DONE;
                                cnt_d   = '0;
                            end
                        end
                        S_MY: begin
                            state_d = S_CG;
                            cnt_d   = GREEN_LD;
                        end
                        S_CG: begin
                            state_d = S_CY;
                            cnt_d   = YELLOW_LD;
                        end
                        S_BLINK_ON: begin
                            state_d = S_BLINK_OFF;
                            cnt_d   = BLINK_LD;
                        end
                        S_BLINK_OFF: begin
                            if (blink2_q) begin
                                state_d = S_DONE;
                                cnt_d   = '0;
                            end else begin
                                state_d  = S_BLINK_ON;
                                cnt_d    = BLINK_LD;
                                blink2_d = 1'b1;
                            end
                        end
                        default: begin
                            // S_CY, S_ALLRED and any unused encoding
                            state_d = S_DONE;
                            cnt_d   = '0;
                        end
                    endcase
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the next state so that outputs are registered
    // and line up with the state they describe
    // ------------------------------------------------------------------
    always_comb begin
        main_d  = main_q;
        cntry_d = cntry_q;
        case (state_d)
            S_MG: begin
                main_d  = L_GRN;
                cntry_d = L_RED;
            end
            S_MY: begin
                main_d  = L_YEL;
                cntry_d = L_RED;
            end
            S_CG: begin
                main_d  = L_RED;
                cntry_d = L_GRN;
            end
            S_CY: begin
                main_d  = L_RED;
                cntry_d = L_YEL;
            end
            S_ALLRED: begin
                main_d  = L_RED;
                cntry_d = L_RED;
            end
            S_BLINK_ON: begin
                main_d  = L_YEL;
                cntry_d = L_YEL;
            end
            S_BLINK_OFF: begin
                main_d  = L_OFF;
                cntry_d = L_OFF;
            end
            S_DONE: begin
                main_d  = L_GRN;
                cntry_d = L_RED;
            end
            default: begin
                // IDLE holds whatever was last shown: all red after reset,
                // main green after a completed phase
                main_d  = main_q;
                cntry_d = cntry_q;
            end
        endcase
    end

    always_comb begin
        busy_d = (state_d != S_IDLE);
        err_d  = accept && multi_hot;
        fb_d   = '0;
        if (state_d == S_DONE) begin
            fb_d = 6'b000001 << mode_d;
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mode_q   <= M_ONLINE;
            blink2_q <= 1'b0;
            main_q   <= L_RED;
            cntry_q  <= L_RED;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            fb_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            blink2_q <= blink2_d;
            main_q   <= main_d;
            cntry_q  <= cntry_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            fb_q     <= fb_d;
        end
    end

    assign main_lt        = main_q;
    assign cntry_lt       = cntry_q;
    assign count          = cnt_q;
    assign busy           = busy_q;
    assign err            = err_q;
    assign feedbackOnline = fb_q[0];
    assign feedbackRst    = fb_q[1];
    assign feedback4      = fb_q[2];
    assign feedback3      = fb_q[3];
    assign feedback2      = fb_q[4];
    assign feedback1      = fb_q[5];

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
module tb_traffic_phase_sequencer;

    localparam int GT = 8;
    localparam int YT = 3;
    localparam int AT = 2;
    localparam int BT = 2;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    enb;
    logic [2:0]    main_lt;
    logic [2:0]    cntry_lt;
    logic [CW-1:0] count;
    logic          busy;
    logic          err;
    logic          feedback1, feedback2, feedback3, feedback4;
    logic          feedbackRst, feedbackOnline;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    traffic_phase_sequencer #(
        .GREEN_T (GT),
        .YELLOW_T(YT),
        .ALLRED_T(AT),
        .BLINK_T (BT),
        .CNT_W   (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enb           (enb),
        .main_lt       (main_lt),
        .cntry_lt      (cntry_lt),
        .count         (count),
        .busy          (busy),
        .err           (err),
        .feedback1     (feedback1),
        .feedback2     (feedback2),
        .feedback3     (feedback3),
        .feedback4     (feedback4),
        .feedbackRst   (feedbackRst),
        .feedbackOnline(feedbackOnline)
    );

    // feedback bit i answers enb[i]
    wire [5:0] fbv = {feedback1, feedback2, feedback3, feedback4, feedbackRst, feedbackOnline};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a phase is a list of (lamps, duration) steps, then
    // one DONE cycle, then IDLE. Expected per-cycle outputs are queued.
    // ------------------------------------------------------------------
    typedef struct {
        logic [2:0] m;
        logic [2:0] c;
        int         cnt;
        bit         busy;
        int         fb;
        bit         err;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   mvalid = 0;

    function automatic void add_step(logic [2:0] m, logic [2:0] c, int t);
        for (int i = 0; i < t; i++) q.push_back('{m, c, t - 1 - i, 1'b1, -1, 1'b0});
    endfunction

    function automatic void build(int idx);
        case (idx)
            5: begin
                add_step(3'b001, 3'b100, GT); add_step(3'b010, 3'b100, YT);
                add_step(3'b100, 3'b001, GT); add_step(3'b100, 3'b010, YT);
            end
            4, 3: add_step(3'b001, 3'b100, GT);
            2: begin
                add_step(3'b010, 3'b100, YT);
                add_step(3'b100, 3'b001, GT); add_step(3'b100, 3'b010, YT);
            end
            1: add_step(3'b100, 3'b100, AT);
            default: begin
                for (int r = 0; r < 2; r++) begin
                    add_step(3'b010, 3'b010, BT); add_step(3'b000, 3'b000, BT);
                end
            end
        endcase
        q.push_back('{3'b001, 3'b100, 0, 1'b1, idx, 1'b0});
        q.push_back('{3'b001, 3'b100, 0, 1'b0, -1, 1'b0});
    endfunction

    always @(posedge clk) begin
        if (rst === 1'b0) begin
            q.delete();
            cur    = '{3'b100, 3'b100, 0, 1'b0, -1, 1'b0};
            mvalid = 1;
        end else if (mvalid) begin
            if (q.size() > 0) begin
                cur = q.pop_front();
            end else if (enb != 6'd0) begin
                int idx = 0;
                for (int i = 5; i >= 0; i--) if (enb[i]) idx = i;
                build(idx);
                cur     = q.pop_front();
                cur.err = ($countones(enb) > 1);
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (mvalid) begin
            logic [5:0] efb;
            efb = (cur.fb < 0) ? 6'd0 : (6'd1 << cur.fb);
            chk("model main_lt", main_lt, cur.m);
            chk("model cntry_lt", cntry_lt, cur.c);
            chk("model count", count, cur.cnt);
            chk("model busy", busy, cur.busy);
            chk("model err", err, cur.err);
            chk("model feedback", fbv, efb);
            chk("inv one feedback", ($countones(fbv) <= 1), 1);
        end
    end

    task automatic wait_idle();
        enb = 6'd0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy === 1'b0) return;
        end
        chk("wait_idle timeout", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        enb = 6'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle main red", main_lt, 3'b100);
        chk("idle cntry red", cntry_lt, 3'b100);
        chk("idle busy", busy, 0);
        chk("idle count", count, 0);

        // main only
        wait_idle();
        enb = 6'b001000;
        @(negedge clk); enb = 6'd0;               // cycle 1
        chk("main c1 lamp", main_lt, 3'b001);
        chk("main c1 count", count, 7);
        repeat (7) @(negedge clk);                // cycle 8
        chk("main c8 count", count, 0);
        @(negedge clk);                           // cycle 9
        chk("main c9 feedback3", feedback3, 1);
        @(negedge clk);                           // cycle 10
        chk("main c10 busy", busy, 0);
        chk("main c10 feedback3", feedback3, 0);

        // both roads, enb held so it re-arms
        wait_idle();
        enb = 6'b100000;
        @(negedge clk);                           // cycle 1
        chk("both c1 main", main_lt, 3'b001);
        repeat (8) @(negedge clk);                // cycle 9
        chk("both c9 main yellow", main_lt, 3'b010);
        chk("both c9 count", count, 2);
        repeat (3) @(negedge clk);                // cycle 12
        chk("both c12 cntry green", cntry_lt, 3'b001);
        repeat (8) @(negedge clk);                // cycle 20
        chk("both c20 cntry yellow", cntry_lt, 3'b010);
        repeat (3) @(negedge clk);                // cycle 23
        chk("both c23 feedback1", feedback1, 1);
        @(negedge clk);                           // cycle 24
        chk("both c24 busy", busy, 0);
        @(negedge clk);                           // cycle 25
        chk("both c25 busy", busy, 1);
        chk("both c25 count", count, 7);
        enb = 6'd0;

        // online blink
        wait_idle();
        enb = 6'b000001;
        @(negedge clk); enb = 6'd0;               // cycle 1
        chk("blink c1 lamps", {main_lt, cntry_lt}, 6'b010010);
        repeat (2) @(negedge clk);                // cycle 3
        chk("blink c3 lamps", {main_lt, cntry_lt}, 6'b000000);
        repeat (2) @(negedge clk);                // cycle 5
        chk("blink c5 lamps", {main_lt, cntry_lt}, 6'b010010);
        repeat (4) @(negedge clk);                // cycle 9
        chk("blink c9 feedbackOnline", feedbackOnline, 1);

        // multi-hot
        wait_idle();
        enb = 6'b000011;
        @(negedge clk); enb = 6'd0;               // cycle 1
        chk("multi c1 err", err, 1);
        chk("multi c1 main", main_lt, 3'b010);
        @(negedge clk);
        chk("multi c2 err", err, 0);

        // reset during country green
        wait_idle();
        enb = 6'b000100;
        @(negedge clk);                           // cycle 1
        chk("crst c1 main", main_lt, 3'b010);
        repeat (4) @(negedge clk);                // cycle 5
        chk("crst c5 cntry", cntry_lt, 3'b001);
        rst = 1'b0;
        @(negedge clk);                           // cycle 6
        chk("crst c6 lamps", {main_lt, cntry_lt}, 6'b100100);
        chk("crst c6 busy", busy, 0);
        chk("crst c6 count", count, 0);
        rst = 1'b1;
        @(negedge clk);                           // cycle 7
        chk("crst c7 busy", busy, 1);
        chk("crst c7 main", main_lt, 3'b010);
        enb = 6'd0;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 199) < 2) ? 1'b0 : 1'b1;
            case ($urandom_range(0, 5))
                0:       enb = 6'($urandom_range(0, 63));
                1, 2:    enb = 6'd1 << $urandom_range(0, 5);
                default: enb = 6'd0;
            endcase
        end
        rst = 1'b1;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
